alu_immediate_pipe: RTL and testbench

ALU_IMMEDIATE_PIPE -- requirements
Module: alu_immediate_pipe

---
 rtl/alu_imm_pkg.sv | 34 +++
 rtl/alu_immediate_pipe_if.sv | 26 ++
 rtl/alu_imm_shifter.sv | 74 +++++++
 rtl/alu_immediate_pipe.sv | 130 +++++++++++++
 tb/tb_alu_immediate_pipe.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_imm_pkg.sv
// Shared definitions for the OP-IMM ALU pipe: funct3 encodings, control states
// and the shift-encoding legality check.
package alu_imm_pkg;

  localparam logic [2:0] F3_ADDI      = 3'd0;
  localparam logic [2:0] F3_SLLI      = 3'd1;
  localparam logic [2:0] F3_SLTI      = 3'd2;
  localparam logic [2:0] F3_SLTIU     = 3'd3;
  localparam logic [2:0] F3_XORI      = 3'd4;
  localparam logic [2:0] F3_SRLI_SRAI = 3'd5;
  localparam logic [2:0] F3_ORI       = 3'd6;
  localparam logic [2:0] F3_ANDI      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] f3);
    return (f3 == F3_SLLI) || (f3 == F3_SRLI_SRAI);
  endfunction

  // Reserved immediate bits of a shift; imm[5] is only a shamt bit on 64-bit.
  function automatic logic shift_enc_illegal(input logic [2:0] f3,
                                             input logic [11:0] imm12,
                                             input logic xlen64);
    logic bad;
    bad = imm12[11] || (imm12[9:6] != 4'd0) || (!xlen64 && imm12[5]) ||
          ((f3 == F3_SLLI) && imm12[10]);
    return is_shift_op(f3) && bad;
  endfunction

endpackage

// File: rtl/alu_immediate_pipe_if.sv
// Operation/result handshake bundle between a producer and the OP-IMM ALU pipe.
interface alu_immediate_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [4:0]      rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd_value;
  logic [4:0]      rd_addr_out;
  logic            illegal;

  modport master (
    output in_valid, funct3, imm, rs1, rd_addr, out_ready,
    input  in_ready, out_valid, rd_value, rd_addr_out, illegal
  );

  modport slave (
    input  in_valid, funct3, imm, rs1, rd_addr, out_ready,
    output in_ready, out_valid, rd_value, rd_addr_out, illegal
  );
endinterface

// File: rtl/alu_imm_shifter.sv
// Iterative shifter: moves at most SHIFT_STEP positions per cycle; value_o is the
// result of the current step, complete when done_o is high.
module alu_imm_shifter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [XLEN-1:0]         operand_i,
  input  logic [$clog2(XLEN)-1:0] amount_i,
  input  logic                    direction_i,
  input  logic                    arithmetic_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         value_o
);
  localparam int AW = $clog2(XLEN);
  localparam logic [AW:0] STEP_L = (AW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] value_q;
  logic [AW-1:0]   rem_q;
  logic            right_q;
  logic            arith_q;
  logic            busy_q;
  logic [AW:0]     step_s;
  logic            last_s;

  // Step size and shifted value for the current cycle.
  always_comb begin
    step_s = STEP_L;
    if ({1'b0, rem_q} > STEP_L) begin
      step_s = STEP_L;
    end else begin
      step_s = {1'b0, rem_q};
    end
    last_s = ({1'b0, rem_q} <= STEP_L);
    value_o = value_q;
    if (right_q && arith_q) begin
      value_o = $signed(value_q) >>> step_s;
    end else if (right_q) begin
      value_o = value_q >> step_s;
    end else begin
      value_o = value_q << step_s;
    end
  end

  // Operand/remaining-count registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      value_q <= {XLEN{1'b0}};
      rem_q   <= {AW{1'b0}};
      right_q <= 1'b0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      value_q <= operand_i;
      rem_q   <= amount_i;
      right_q <= direction_i;
      arith_q <= arithmetic_i;
      busy_q  <= (amount_i != {AW{1'b0}});
    end else if (busy_q) begin
      value_q <= value_o;
      rem_q   <= rem_q - step_s[AW-1:0];
      busy_q  <= !last_s;
    end else begin
      value_q <= value_q;
      rem_q   <= rem_q;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && last_s;
endmodule

// File: rtl/alu_immediate_pipe.sv
// RISC-V OP-IMM execute unit: single-cycle ALU ops, iterative shifts, and a
// valid/ready result register that holds until the consumer takes it.
module alu_immediate_pipe
  import alu_imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                clock,
  input  logic                reset,
  alu_immediate_pipe_if.slave bus
);
  localparam int AW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] rd_value_q, rd_value_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [4:0]      pend_addr_q, pend_addr_d;
  logic            illegal_q, illegal_d;

  logic            in_ready_s, accept_s, enc_illegal_s, go_shift_s, sh_start_s;
  logic [AW-1:0]   shamt_s;
  logic [XLEN-1:0] alu_result_s, sh_value_s;
  logic            sh_done_s;

  assign in_ready_s    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign shamt_s       = bus.imm[AW-1:0];
  assign enc_illegal_s = shift_enc_illegal(bus.funct3, bus.imm[11:0], (XLEN == 64));
  assign go_shift_s    = is_shift_op(bus.funct3) && !enc_illegal_s && (shamt_s != {AW{1'b0}});

  // Single-cycle ALU; shift ops here only cover the zero-amount case.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    case (bus.funct3)
      F3_ADDI:      alu_result_s = bus.rs1 + bus.imm;
      F3_SLTI:      alu_result_s = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.imm))};
      F3_SLTIU:     alu_result_s = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.imm)};
      F3_XORI:      alu_result_s = bus.rs1 ^ bus.imm;
      F3_ORI:       alu_result_s = bus.rs1 | bus.imm;
      F3_ANDI:      alu_result_s = bus.rs1 & bus.imm;
      F3_SLLI:      alu_result_s = bus.rs1;
      F3_SRLI_SRAI: alu_result_s = bus.rs1;
      default:      alu_result_s = {XLEN{1'b0}};
    endcase
  end

  // Next state and result-register loads.
  always_comb begin
    state_d     = state_q;
    rd_value_d  = rd_value_q;
    rd_addr_d   = rd_addr_q;
    illegal_d   = illegal_q;
    pend_addr_d = pend_addr_q;
    sh_start_s  = 1'b0;
    if (accept_s) begin
      if (go_shift_s) begin
        state_d     = ST_SHIFT;
        sh_start_s  = 1'b1;
        pend_addr_d = bus.rd_addr;
      end else begin
        state_d    = ST_DONE;
        rd_value_d = enc_illegal_s ? {XLEN{1'b0}} : alu_result_s;
        rd_addr_d  = bus.rd_addr;
        illegal_d  = enc_illegal_s;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_SHIFT: begin
          if (sh_done_s) begin
            state_d    = ST_DONE;
            rd_value_d = sh_value_s;
            rd_addr_d  = pend_addr_q;
            illegal_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_value_q  <= {XLEN{1'b0}};
      rd_addr_q   <= 5'd0;
      pend_addr_q <= 5'd0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_value_q  <= rd_value_d;
      rd_addr_q   <= rd_addr_d;
      pend_addr_q <= pend_addr_d;
      illegal_q   <= illegal_d;
    end
  end

  alu_imm_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (sh_start_s),
    .operand_i    (bus.rs1),
    .amount_i     (shamt_s),
    .direction_i  (bus.funct3 == F3_SRLI_SRAI),
    .arithmetic_i (bus.imm[10]),
    .busy_o       (),
    .done_o       (sh_done_s),
    .value_o      (sh_value_s)
  );

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.rd_value    = rd_value_q;
  assign bus.rd_addr_out = rd_addr_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_immediate_pipe.sv
// Directed bench for alu_immediate_pipe at XLEN 32, SHIFT_STEP 4.
module tb_alu_immediate_pipe;
  import alu_imm_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  alu_immediate_pipe_if #(.XLEN(32)) bus ();

  alu_immediate_pipe #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Offers one op in IDLE, then counts cycles from the accept edge to out_valid.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [4:0] addr, output int lat);
    bus.in_valid = 1'b1;
    bus.funct3 = f3;
    bus.imm = imm;
    bus.rs1 = rs1;
    bus.rd_addr = addr;
    bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    bus.imm = 32'hFFFF_FFFF;
    bus.rs1 = 32'hDEAD_BEEF;
    bus.rd_addr = 5'd31;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3 = 3'd0;
    bus.imm = 32'd0;
    bus.rs1 = 32'd0;
    bus.rd_addr = 5'd0;
    tick;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.rd_value !== 32'd0 || bus.rd_addr_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b ill=%b val=%h tag=%h want 0 0 0 0",
               bus.out_valid, bus.illegal, bus.rd_value, bus.rd_addr_out);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_alu_ops;
    logic [2:0]  f3_t  [10] = '{F3_ADDI, F3_SLTI, F3_SLTIU, F3_XORI, F3_ORI, F3_ANDI,
                                F3_ADDI, F3_SLLI, F3_SRLI_SRAI, F3_SRLI_SRAI};
    logic [31:0] imm_t [10] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                                32'h0000_0FF0, 32'hFFFF_FF0F, 32'h0000_0420, 32'h0000_0420,
                                32'h0000_0029, 32'hFFFF_F809};
    logic [31:0] rs1_t [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hF0F0_F0F0,
                                32'h0000_000F, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001,
                                32'h8000_0000, 32'h8000_0000};
    logic [31:0] exp_t [10] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0F0F_0F0F,
                                32'h0000_0FFF, 32'h1234_5608, 32'h0000_0430, 32'h0000_0000,
                                32'h0000_0000, 32'h0000_0000};
    logic        ill_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(f3_t[i], imm_t[i], rs1_t[i], 5'(i + 1), lat);
      checks++;
      if (lat !== 1 || bus.rd_value !== exp_t[i] || bus.illegal !== ill_t[i] || bus.rd_addr_out !== 5'(i + 1)) begin
        errors++;
        $display("FAIL alu_op%0d got lat=%0d val=%h ill=%b tag=%0d want lat=1 val=%h ill=%b tag=%0d",
                 i, lat, bus.rd_value, bus.illegal, bus.rd_addr_out, exp_t[i], ill_t[i], i + 1);
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.rd_value !== exp_t[i]) begin
        errors++;
        $display("FAIL alu_release%0d got v=%b val=%h want v=0 val=%h", i, bus.out_valid, bus.rd_value, exp_t[i]);
      end
    end
  endtask

  task automatic test_shift;
    logic [2:0]  f3_t  [7] = '{F3_SRLI_SRAI, F3_SRLI_SRAI, F3_SLLI, F3_SLLI,
                               F3_SRLI_SRAI, F3_SRLI_SRAI, F3_SRLI_SRAI};
    logic [31:0] imm_t [7] = '{32'h0000_0409, 32'h0000_0009, 32'h0000_0004, 32'h0000_001F,
                               32'h0000_0400, 32'h0000_041F, 32'h0000_0404};
    logic [31:0] rs1_t [7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001,
                               32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF0};
    logic [31:0] exp_t [7] = '{32'hFFC0_0000, 32'h0040_0000, 32'h0000_0010, 32'h8000_0000,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'h07FF_FFFF};
    int          lat_t [7] = '{4, 4, 2, 9, 1, 9, 2};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(f3_t[i], imm_t[i], rs1_t[i], 5'(i + 16), lat);
      checks++;
      if (lat !== lat_t[i] || bus.rd_value !== exp_t[i] || bus.illegal !== 1'b0 || bus.rd_addr_out !== 5'(i + 16)) begin
        errors++;
        $display("FAIL shift%0d got lat=%0d val=%h ill=%b tag=%0d want lat=%0d val=%h ill=0 tag=%0d",
                 i, lat, bus.rd_value, bus.illegal, bus.rd_addr_out, lat_t[i], exp_t[i], i + 16);
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(F3_XORI, 32'hFFFF_FFFF, 32'h0000_FFFF, 5'd5, lat);
    bus.in_valid = 1'b1;
    bus.funct3 = F3_ADDI;
    bus.imm = 32'd3;
    bus.rs1 = 32'd5;
    bus.rd_addr = 5'd9;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.rd_value !== 32'hFFFF_0000 || bus.rd_addr_out !== 5'd5 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got v=%b val=%h tag=%0d rdy=%b want 1 ffff0000 5 0",
                 i, bus.out_valid, bus.rd_value, bus.rd_addr_out, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1", bus.in_ready);
    end
    tick;
    bus.funct3 = F3_SLLI;
    bus.imm = 32'h0000_0004;
    bus.rs1 = 32'h0000_0003;
    bus.rd_addr = 5'd2;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd_value !== 32'd8 || bus.rd_addr_out !== 5'd9) begin
      errors++;
      $display("FAIL b2b_addi got v=%b val=%h tag=%0d want 1 00000008 9", bus.out_valid, bus.rd_value, bus.rd_addr_out);
    end
    tick;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rd_value !== 32'd8) begin
      errors++;
      $display("FAIL b2b_shift_start got v=%b val=%h want 0 00000008", bus.out_valid, bus.rd_value);
    end
    tick;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd_value !== 32'h0000_0030 || bus.rd_addr_out !== 5'd2) begin
      errors++;
      $display("FAIL b2b_shift got v=%b val=%h tag=%0d want 1 00000030 2", bus.out_valid, bus.rd_value, bus.rd_addr_out);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    int lat;
    int seen;
    bus.in_valid = 1'b1;
    bus.funct3 = F3_SRLI_SRAI;
    bus.imm = 32'h0000_0409;
    bus.rs1 = 32'h8000_0000;
    bus.rd_addr = 5'd7;
    tick;
    bus.in_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.rd_value !== 32'd0) begin
      errors++;
      $display("FAIL rst_shift got v=%b rdy=%b val=%h want 0 1 0", bus.out_valid, bus.in_ready, bus.rd_value);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_shift_quiet got %0d bad cycles want 0", seen);
    end
    do_op(F3_ORI, 32'h0000_0001, 32'h0000_0100, 5'd3, lat);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rd_value !== 32'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_done got v=%b val=%h rdy=%b want 0 0 1", bus.out_valid, bus.rd_value, bus.in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_shift;
    test_back_to_back;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
